aes_cmd_sequencer: RTL

Command sequencer between the 18-byte UART frame interface (uart_top) and the AES coprocessor cores (aes_cipher_top, aes_inv_cipher_top).
- Validates each received frame, executes the opcode, and owns the key/text registers.
- Issues single-cycle ld/kld strobes, waits for the done pulses with a watchdog, captures results, and emits one response frame per command.
- Replaces ad-hoc per-cycle decode; one command in flight at a time.

---
 rtl/aes_seq_pkg.sv | 45 ++++
 rtl/aes_seq_watchdog.sv | 46 ++++
 rtl/aes_cmd_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_seq_pkg.sv
// ============================================================================
// Module      : aes_seq_pkg
// Description : Opcode/status bytes, frame width and FSM state encoding
//               shared by the AES command sequencer and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_seq_pkg;

    localparam int FRAME_W = 144;

    // Command opcodes (ASCII)
    localparam logic [7:0] OP_KEY   = 8'h43;  // "C"
    localparam logic [7:0] OP_TEXT  = 8'h44;  // "D"
    localparam logic [7:0] OP_ENC   = 8'h45;  // "E"
    localparam logic [7:0] OP_DEC   = 8'h4B;  // "K"
    localparam logic [7:0] RD_ENC   = 8'h40;  // "@"
    localparam logic [7:0] RD_DEC   = 8'h60;  // ASCII grave accent (0x60)
    localparam logic [7:0] RD_KEY   = 8'h61;  // "a"
    localparam logic [7:0] RD_TEXT  = 8'h62;  // "b"
    localparam logic [7:0] PING     = 8'h41;  // "A"

    // Status-only bytes
    localparam logic [7:0] ST_ERR   = 8'h21;  // "!"
    localparam logic [7:0] ST_TMO   = 8'h54;  // "T"
    localparam logic [7:0] ST_VFAIL = 8'h58;  // "X"

    localparam logic [127:0] PING_RESULT = "1234567890123456";

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_ENC_WAIT  = 3'd2;
    localparam logic [2:0] S_KEXP_WAIT = 3'd3;
    localparam logic [2:0] S_DEC_WAIT  = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;
    localparam logic [2:0] S_RESP_HOLD = 3'd6;

    function automatic logic is_wait_state(input logic [2:0] s);
        return (s == S_ENC_WAIT) || (s == S_KEXP_WAIT) || (s == S_DEC_WAIT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_seq_watchdog.sv
// ============================================================================
// Module      : aes_seq_watchdog
// Description : Cycle counter for the sequencer wait states; flags expiry on
//               the last permitted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a stalled enable can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/aes_cmd_sequencer.sv
// ============================================================================
// Module      : aes_cmd_sequencer
// Description : Validates UART command frames, drives the AES cipher/inverse
//               cores and returns one response frame per command.
//               Optional build macro: AES_SEQ_AUTOVERIFY_EN (decrypt-back check).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_cmd_sequencer
  import aes_seq_pkg::*;
#(
  parameter int           FRAME_BYTES    = 18,
  parameter int           TIMEOUT_CYCLES = 64,
  parameter logic [127:0] KEY_INIT       = 128'h0,
  parameter logic [127:0] TEXT_INIT      = 128'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [8*FRAME_BYTES-1:0] rx_frame,
  output logic                     rx_pop,
  input  logic                     tx_busy,
  output logic [8*FRAME_BYTES-1:0] tx_frame,
  output logic                     tx_send,
  output logic [127:0]             enc_key,
  output logic [127:0]             enc_text,
  output logic                     enc_ld,
  input  logic                     enc_done,
  input  logic [127:0]             enc_out,
  output logic [127:0]             dec_key,
  output logic [127:0]             dec_text,
  output logic                     dec_kld,
  output logic                     dec_ld,
  input  logic                     dec_kdone,
  input  logic                     dec_done,
  input  logic [127:0]             dec_out,
  output logic                     busy
);

  localparam int FW = 8 * FRAME_BYTES;

  logic [2:0]    state_q, state_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  text_q, text_d;
  logic [127:0]  enc_res_q, enc_res_d;
  logic [127:0]  dec_res_q, dec_res_d;
  logic [127:0]  result_q, result_d;
  logic [7:0]    status_q, status_d;
  logic [FW-1:0] tx_frame_q, tx_frame_d;
  logic          tx_send_q, tx_send_d;
  logic          enc_ld_q, enc_ld_d;
  logic          dec_kld_q, dec_kld_d;
  logic          dec_ld_q, dec_ld_d;
`ifdef AES_SEQ_AUTOVERIFY_EN
  logic          verify_q, verify_d;
`endif

  logic [7:0]    op_w;
  logic [7:0]    chk_w;
  logic [127:0]  payload_w;
  logic          frame_ok_w;
  logic          wd_en_w;
  logic          wd_clr_w;
  logic          wd_expired_w;

  assign op_w       = rx_frame[7:0];
  assign chk_w      = rx_frame[FW-1 -: 8];
  assign payload_w  = rx_frame[8 +: 128];
  assign frame_ok_w = (op_w == chk_w);

  // Any state change restarts the count, including KEXP_WAIT -> DEC_WAIT.
  assign wd_en_w  = is_wait_state(state_q);
  assign wd_clr_w = (state_d != state_q);

  aes_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (wd_clr_w),
    .en_i      (wd_en_w),
    .expired_o (wd_expired_w)
  );

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    text_d     = text_q;
    enc_res_d  = enc_res_q;
    dec_res_d  = dec_res_q;
    result_d   = result_q;
    status_d   = status_q;
    tx_frame_d = tx_frame_q;
    tx_send_d  = 1'b0;
    enc_ld_d   = 1'b0;
    dec_kld_d  = 1'b0;
    dec_ld_d   = 1'b0;
`ifdef AES_SEQ_AUTOVERIFY_EN
    verify_d   = verify_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d  = S_RESP;
        status_d = op_w;
        result_d = '0;
`ifdef AES_SEQ_AUTOVERIFY_EN
        verify_d = 1'b0;
`endif
        if (!frame_ok_w) begin
          status_d = ST_ERR;
        end else begin
          case (op_w)
            OP_KEY: begin
              key_d    = payload_w;
              result_d = payload_w;
            end
            OP_TEXT: begin
              text_d   = payload_w;
              result_d = payload_w;
            end
            OP_ENC: begin
              enc_ld_d = 1'b1;
              state_d  = S_ENC_WAIT;
            end
            OP_DEC: begin
              dec_kld_d = 1'b1;
              state_d   = S_KEXP_WAIT;
            end
            RD_ENC:  result_d = enc_res_q;
            RD_DEC:  result_d = dec_res_q;
            RD_KEY:  result_d = key_q;
            RD_TEXT: result_d = text_q;
            PING:    result_d = PING_RESULT;
            default: status_d = ST_ERR;
          endcase
        end
      end

      // A done pulse wins over a same-cycle watchdog expiry.
      S_ENC_WAIT: begin
        if (enc_done) begin
          enc_res_d = enc_out;
          result_d  = enc_out;
          status_d  = OP_ENC;
`ifdef AES_SEQ_AUTOVERIFY_EN
          verify_d  = 1'b1;
          dec_kld_d = 1'b1;
          state_d   = S_KEXP_WAIT;
`else
          state_d   = S_RESP;
`endif
        end else if (wd_expired_w) begin
          status_d = ST_TMO;
          result_d = '0;
          state_d  = S_RESP;
        end
      end

      S_KEXP_WAIT: begin
        if (dec_kdone) begin
          dec_ld_d = 1'b1;
          state_d  = S_DEC_WAIT;
        end else if (wd_expired_w) begin
          status_d = ST_TMO;
          result_d = '0;
          state_d  = S_RESP;
        end
      end

      S_DEC_WAIT: begin
        if (dec_done) begin
          dec_res_d = dec_out;
          state_d   = S_RESP;
`ifdef AES_SEQ_AUTOVERIFY_EN
          if (verify_q) begin
            status_d = (dec_out == text_q) ? OP_ENC : ST_VFAIL;
          end else begin
            status_d = OP_DEC;
            result_d = dec_out;
          end
`else
          status_d = OP_DEC;
          result_d = dec_out;
`endif
        end else if (wd_expired_w) begin
          status_d = ST_TMO;
          result_d = '0;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        if (!tx_busy) begin
          tx_frame_d = {status_q, result_q, status_q};
          tx_send_d  = 1'b1;
          state_d    = S_RESP_HOLD;
        end
      end

      S_RESP_HOLD: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      key_q      <= KEY_INIT;
      text_q     <= TEXT_INIT;
      enc_res_q  <= '0;
      dec_res_q  <= '0;
      result_q   <= '0;
      status_q   <= '0;
      tx_frame_q <= '0;
      tx_send_q  <= 1'b0;
      enc_ld_q   <= 1'b0;
      dec_kld_q  <= 1'b0;
      dec_ld_q   <= 1'b0;
`ifdef AES_SEQ_AUTOVERIFY_EN
      verify_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      text_q     <= text_d;
      enc_res_q  <= enc_res_d;
      dec_res_q  <= dec_res_d;
      result_q   <= result_d;
      status_q   <= status_d;
      tx_frame_q <= tx_frame_d;
      tx_send_q  <= tx_send_d;
      enc_ld_q   <= enc_ld_d;
      dec_kld_q  <= dec_kld_d;
      dec_ld_q   <= dec_ld_d;
`ifdef AES_SEQ_AUTOVERIFY_EN
      verify_q   <= verify_d;
`endif
    end
  end

  // The frame is still on rx_frame during DECODE; the pop retires it.
  assign rx_pop   = (state_q == S_DECODE);
  assign busy     = (state_q != S_IDLE);
  assign tx_frame = tx_frame_q;
  assign tx_send  = tx_send_q;
  assign enc_ld   = enc_ld_q;
  assign dec_kld  = dec_kld_q;
  assign dec_ld   = dec_ld_q;
  assign enc_key  = key_q;
  assign dec_key  = key_q;
  assign enc_text = text_q;
`ifdef AES_SEQ_AUTOVERIFY_EN
  assign dec_text = verify_q ? enc_res_q : text_q;
`else
  assign dec_text = text_q;
`endif

endmodule

`default_nettype wire
